// File: rtl/snn_interfaces_pkg.sv
// Shared types for the event-driven conv core: coordinate pair, packing helpers
// and the scheduler state encoding.
package snn_interfaces_pkg;

    localparam int VEC_COORD_BITS = 8;

    typedef struct packed {
        logic [VEC_COORD_BITS-1:0] x;
        logic [VEC_COORD_BITS-1:0] y;
    } vec2_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        WINDOW = 2'd2,
        SWEEP  = 2'd3
    } sched_state_t;

    // FIFO word layout is {x, y}, x in the upper half.
    function automatic logic [2*VEC_COORD_BITS-1:0] pack_coordinates(
        input logic [VEC_COORD_BITS-1:0] x,
        input logic [VEC_COORD_BITS-1:0] y
    );
        return {x, y};
    endfunction

    function automatic vec2_t unpack_coordinates(input logic [2*VEC_COORD_BITS-1:0] word);
        vec2_t v;
        v.x = word[2*VEC_COORD_BITS-1:VEC_COORD_BITS];
        v.y = word[VEC_COORD_BITS-1:0];
        return v;
    endfunction

endpackage

// File: rtl/kernel_window_iter.sv
// Walks the KxK kernel window around an event (j outer, i inner) and keeps the
// current output coordinate, weight index and last-position flag in registers.
// nxt_in_bounds describes the position being loaded this cycle so the caller
// can register its valid flag alongside the coordinates.
module kernel_window_iter
    import snn_interfaces_pkg::*;
#(
    parameter int COORD_BITS  = 8,
    parameter int IMG_WIDTH   = 32,
    parameter int IMG_HEIGHT  = 32,
    parameter int KERNEL_SIZE = 3,
    parameter int KIDX_BITS   = $clog2(KERNEL_SIZE*KERNEL_SIZE)
) (
    input  logic                  clk,
    input  logic                  sys_reset,
    input  logic                  start,
    input  logic                  advance,
    input  logic [COORD_BITS-1:0] base_x,
    input  logic [COORD_BITS-1:0] base_y,
    output logic [COORD_BITS-1:0] ox,
    output logic [COORD_BITS-1:0] oy,
    output logic [KIDX_BITS-1:0]  kidx,
    output logic                  last,
    output logic                  nxt_in_bounds
);

    localparam int SW = COORD_BITS + 1;
    localparam int CW = $clog2(KERNEL_SIZE + 1);
    localparam int R  = KERNEL_SIZE / 2;

    logic [CW-1:0]        i_q, j_q, i_n, j_n;
    logic [SW-1:0]        ox_n, oy_n;
    logic [KIDX_BITS-1:0] kidx_n;
    logic                 last_n;

    // Next window position and its coordinates; signed range handled via the extra MSB.
    always_comb begin
        i_n = i_q;
        j_n = j_q;
        if (start) begin
            i_n = '0;
            j_n = '0;
        end else if (advance) begin
            if (i_q == CW'(KERNEL_SIZE - 1)) begin
                i_n = '0;
                j_n = j_q + CW'(1);
            end else begin
                i_n = i_q + CW'(1);
            end
        end
        ox_n   = {1'b0, base_x} - SW'(R) + SW'(i_n);
        oy_n   = {1'b0, base_y} - SW'(R) + SW'(j_n);
        kidx_n = KIDX_BITS'(j_n * KERNEL_SIZE + i_n);
        last_n = (i_n == CW'(KERNEL_SIZE - 1)) && (j_n == CW'(KERNEL_SIZE - 1));
        nxt_in_bounds = !ox_n[SW-1] && (ox_n < SW'(IMG_WIDTH)) &&
                        !oy_n[SW-1] && (oy_n < SW'(IMG_HEIGHT));
    end

    // Window counters and registered position outputs.
    always_ff @(posedge clk) begin
        if (sys_reset) begin
            i_q  <= '0;
            j_q  <= '0;
            ox   <= '0;
            oy   <= '0;
            kidx <= '0;
            last <= 1'b0;
        end else if (start || advance) begin
            i_q  <= i_n;
            j_q  <= j_n;
            ox   <= ox_n[COORD_BITS-1:0];
            oy   <= oy_n[COORD_BITS-1:0];
            kidx <= kidx_n;
            last <= last_n;
        end
    end

endmodule

// File: rtl/conv_event_scheduler.sv
// Event/sweep scheduler for the conv core. Pops spike events and issues one
// update per in-bounds kernel position; on timestep (after the FIFO drains)
// sweeps the whole map for decay/fire.
// Handshakes: a request (upd_valid / sweep_valid) is held with stable payload
// until it is accepted (upd_ready, or sweep_ready && !output_fifo_full) on a
// rising clk edge; payload advances only after acceptance.
module conv_event_scheduler
    import snn_interfaces_pkg::*;
#(
    parameter int COORD_BITS  = 8,
    parameter int IMG_WIDTH   = 32,
    parameter int IMG_HEIGHT  = 32,
    parameter int KERNEL_SIZE = 3,
    parameter int KIDX_BITS   = $clog2(KERNEL_SIZE*KERNEL_SIZE)
) (
    input  logic                    clk,
    input  logic                    sys_reset,
    input  logic                    sys_enable,
    input  logic                    timestep,
    input  logic                    fifo_empty,
    output logic                    fifo_rd_en,
    input  logic [2*COORD_BITS-1:0] fifo_data,
    output logic                    upd_valid,
    input  logic                    upd_ready,
    output logic [COORD_BITS-1:0]   upd_x,
    output logic [COORD_BITS-1:0]   upd_y,
    output logic [KIDX_BITS-1:0]    upd_kidx,
    output logic                    sweep_valid,
    input  logic                    sweep_ready,
    output logic [COORD_BITS-1:0]   sweep_x,
    output logic [COORD_BITS-1:0]   sweep_y,
    input  logic                    output_fifo_full,
    output logic                    timestep_done,
    output logic                    timestep_overrun,
    output logic                    system_active,
    output sched_state_t            dbg_state
);

    sched_state_t            state_q, state_d;
    logic [COORD_BITS-1:0]   ex_q, ey_q;
    logic [COORD_BITS-1:0]   sx_d, sy_d;
    logic                    ts_pending;
    logic                    rd_en_d, upd_valid_d, sweep_valid_d, done_d;
    logic                    it_start, it_adv, clear_ts, latch_ev;
    logic                    it_last, it_nxt_inb;
    logic [COORD_BITS-1:0]   base_x, base_y;
    logic                    sweep_accept, sweep_last;

    assign dbg_state    = state_q;
    assign sweep_accept = sweep_valid && sweep_ready && !output_fifo_full;
    assign sweep_last   = (sweep_x == COORD_BITS'(IMG_WIDTH - 1)) &&
                          (sweep_y == COORD_BITS'(IMG_HEIGHT - 1));
    // The iterator loads straight from the FIFO on start, then works off the latched event.
    assign base_x = it_start ? fifo_data[2*COORD_BITS-1:COORD_BITS] : ex_q;
    assign base_y = it_start ? fifo_data[COORD_BITS-1:0]            : ey_q;

    kernel_window_iter #(
        .COORD_BITS (COORD_BITS),
        .IMG_WIDTH  (IMG_WIDTH),
        .IMG_HEIGHT (IMG_HEIGHT),
        .KERNEL_SIZE(KERNEL_SIZE),
        .KIDX_BITS  (KIDX_BITS)
    ) u_iter (
        .clk          (clk),
        .sys_reset    (sys_reset),
        .start        (it_start),
        .advance      (it_adv),
        .base_x       (base_x),
        .base_y       (base_y),
        .ox           (upd_x),
        .oy           (upd_y),
        .kidx         (upd_kidx),
        .last         (it_last),
        .nxt_in_bounds(it_nxt_inb)
    );

    // Next-state and next-output decode.
    always_comb begin
        state_d       = state_q;
        rd_en_d       = 1'b0;
        upd_valid_d   = upd_valid;
        sweep_valid_d = sweep_valid;
        sx_d          = sweep_x;
        sy_d          = sweep_y;
        done_d        = 1'b0;
        it_start      = 1'b0;
        it_adv        = 1'b0;
        clear_ts      = 1'b0;
        latch_ev      = 1'b0;
        unique case (state_q)
            IDLE: begin
                upd_valid_d   = 1'b0;
                sweep_valid_d = 1'b0;
                if (sys_enable) begin
                    if (!fifo_empty) begin
                        rd_en_d = 1'b1;
                        state_d = FETCH;
                    end else if (ts_pending) begin
                        sweep_valid_d = 1'b1;
                        sx_d          = '0;
                        sy_d          = '0;
                        state_d       = SWEEP;
                    end
                end
            end
            FETCH: begin
                // First FETCH cycle carries the pop; the data arrives on the second.
                if (!fifo_rd_en) begin
                    latch_ev    = 1'b1;
                    it_start    = 1'b1;
                    upd_valid_d = it_nxt_inb;
                    state_d     = WINDOW;
                end
            end
            WINDOW: begin
                // Out-of-bounds positions have upd_valid low and step after one cycle.
                if (!upd_valid || upd_ready) begin
                    if (it_last) begin
                        upd_valid_d = 1'b0;
                        state_d     = IDLE;
                    end else begin
                        it_adv      = 1'b1;
                        upd_valid_d = it_nxt_inb;
                    end
                end
            end
            SWEEP: begin
                if (sweep_accept) begin
                    if (sweep_last) begin
                        sweep_valid_d = 1'b0;
                        done_d        = 1'b1;
                        clear_ts      = 1'b1;
                        state_d       = IDLE;
                    end else if (sweep_x == COORD_BITS'(IMG_WIDTH - 1)) begin
                        sx_d = '0;
                        sy_d = sweep_y + COORD_BITS'(1);
                    end else begin
                        sx_d = sweep_x + COORD_BITS'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, registered outputs and latched event coordinate.
    always_ff @(posedge clk) begin
        if (sys_reset) begin
            state_q       <= IDLE;
            fifo_rd_en    <= 1'b0;
            upd_valid     <= 1'b0;
            sweep_valid   <= 1'b0;
            sweep_x       <= '0;
            sweep_y       <= '0;
            timestep_done <= 1'b0;
            system_active <= 1'b0;
            ex_q          <= '0;
            ey_q          <= '0;
        end else begin
            state_q       <= state_d;
            fifo_rd_en    <= rd_en_d;
            upd_valid     <= upd_valid_d;
            sweep_valid   <= sweep_valid_d;
            sweep_x       <= sx_d;
            sweep_y       <= sy_d;
            timestep_done <= done_d;
            system_active <= (state_d != IDLE);
            if (latch_ev) begin
                ex_q <= fifo_data[2*COORD_BITS-1:COORD_BITS];
                ey_q <= fifo_data[COORD_BITS-1:0];
            end
        end
    end

    // Pending timestep flag and sticky overrun; a timestep in the finishing cycle re-arms.
    always_ff @(posedge clk) begin
        if (sys_reset) begin
            ts_pending       <= 1'b0;
            timestep_overrun <= 1'b0;
        end else begin
            if (clear_ts)
                ts_pending <= timestep;
            else if (timestep)
                ts_pending <= 1'b1;
            if (timestep && ts_pending && !clear_ts)
                timestep_overrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_conv_event_scheduler.sv
// Directed bench for conv_event_scheduler (32x32 map, 3x3 kernel).
module tb_conv_event_scheduler;
    import snn_interfaces_pkg::*;

    localparam int CB = 8;
    localparam int W  = 32;
    localparam int H  = 32;
    localparam int KB = 4;

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           sys_reset, sys_enable, timestep, fifo_empty, fifo_rd_en;
    logic [2*CB-1:0] fifo_data;
    logic           upd_valid, upd_ready, sweep_valid, sweep_ready, output_fifo_full;
    logic [CB-1:0]  upd_x, upd_y, sweep_x, sweep_y;
    logic [KB-1:0]  upd_kidx;
    logic           timestep_done, timestep_overrun, system_active;
    sched_state_t   dbg_state;

    int checks = 0;
    int passes = 0;
    int cyc = 0;

    conv_event_scheduler dut (
        .clk(clk), .sys_reset(sys_reset), .sys_enable(sys_enable), .timestep(timestep),
        .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en), .fifo_data(fifo_data),
        .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_x(upd_x), .upd_y(upd_y),
        .upd_kidx(upd_kidx), .sweep_valid(sweep_valid), .sweep_ready(sweep_ready),
        .sweep_x(sweep_x), .sweep_y(sweep_y), .output_fifo_full(output_fifo_full),
        .timestep_done(timestep_done), .timestep_overrun(timestep_overrun),
        .system_active(system_active), .dbg_state(dbg_state)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // input FIFO model: initial block writes, pop process reads
    logic [2*CB-1:0] mem [16];
    logic [3:0] wr_ptr = '0;
    logic [3:0] rd_ptr = '0;
    assign fifo_empty = (wr_ptr == rd_ptr);
    always @(posedge clk) begin
        if (fifo_rd_en && (wr_ptr != rd_ptr)) begin
            fifo_data <= mem[rd_ptr];
            rd_ptr    <= rd_ptr + 4'd1;
        end
    end

    // monitor logs (sampled on negedge)
    logic [2*CB+KB-1:0] upd_q [$];
    int                 upd_cyc_q [$];
    int                 rd_cyc_q [$];
    logic [2*CB-1:0]    sw_q [$];
    int                 sw_cyc_q [$];
    int                 sweep_start_q [$];
    int                 done_q [$];
    logic [2*CB+KB-1:0] exp_q [$];
    int both_cnt = 0, upd_hold_err = 0, sw_hold_err = 0;
    logic upd_hold = 1'b0, sw_hold = 1'b0, sw_prev_v = 1'b0;
    logic [2*CB+KB-1:0] upd_prev = '0;
    logic [2*CB-1:0]    sw_prev = '0;

    always @(negedge clk) begin
        sw_prev_v <= sweep_valid;
        if (sys_reset) begin
            upd_hold <= 1'b0;
            sw_hold  <= 1'b0;
        end else begin
            if (upd_valid && sweep_valid) both_cnt <= both_cnt + 1;
            if (fifo_rd_en) rd_cyc_q.push_back(cyc);
            if (upd_valid && upd_ready) begin
                upd_q.push_back({upd_x, upd_y, upd_kidx});
                upd_cyc_q.push_back(cyc);
            end
            if (sweep_valid && !sw_prev_v) sweep_start_q.push_back(cyc);
            if (sweep_valid && sweep_ready && !output_fifo_full) begin
                sw_q.push_back({sweep_x, sweep_y});
                sw_cyc_q.push_back(cyc);
            end
            if (timestep_done) done_q.push_back(cyc);
            if (upd_hold && (!upd_valid || {upd_x, upd_y, upd_kidx} !== upd_prev))
                upd_hold_err <= upd_hold_err + 1;
            if (sw_hold && (!sweep_valid || {sweep_x, sweep_y} !== sw_prev))
                sw_hold_err <= sw_hold_err + 1;
            upd_hold <= upd_valid && !upd_ready;
            upd_prev <= {upd_x, upd_y, upd_kidx};
            sw_hold  <= sweep_valid && !(sweep_ready && !output_fifo_full);
            sw_prev  <= {sweep_x, sweep_y};
        end
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_event(input logic [CB-1:0] x, input logic [CB-1:0] y);
        mem[wr_ptr] = pack_coordinates(x, y);
        wr_ptr = wr_ptr + 4'd1;
    endtask

    task automatic pulse_ts();
        timestep = 1'b1;
        tick();
        timestep = 1'b0;
    endtask

    task automatic wait_idle_updates(input int target, input int budget);
        for (int n = 0; n < budget; n++) begin
            if (upd_q.size() >= target && dbg_state == IDLE && fifo_empty) break;
            tick();
        end
    endtask

    task automatic wait_done(input int d0, input int budget);
        for (int n = 0; n < budget; n++) begin
            if (done_q.size() > d0) break;
            tick();
        end
    endtask

    task automatic check_expected_updates(input int u0, input string name);
        int k;
        logic [2*CB+KB-1:0] e, g;
        k = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = (u0 + k < upd_q.size()) ? upd_q[u0 + k] : 'x;
            checks++;
            if (g !== e) $display("FAIL %s[%0d]: got x=%0d y=%0d k=%0d want x=%0d y=%0d k=%0d",
                                  name, k, g[19:12], g[11:4], g[3:0], e[19:12], e[11:4], e[3:0]);
            else passes++;
            k++;
        end
    endtask

    task automatic test_reset();
        logic [41:0] outs;
        outs = {fifo_rd_en, upd_valid, upd_x, upd_y, upd_kidx, sweep_valid, sweep_x, sweep_y,
                timestep_done, timestep_overrun, system_active};
        checks++;
        if (outs !== 42'd0) $display("FAIL reset_outputs: got %h want 0", outs); else passes++;
        checks++;
        if (dbg_state !== IDLE) $display("FAIL reset_state: got %0d want 0", dbg_state); else passes++;
    endtask

    task automatic test_single_window();
        int u0, r0, span, lat;
        u0 = upd_q.size();
        r0 = rd_cyc_q.size();
        sys_enable = 1'b1;
        upd_ready  = 1'b1;
        push_event(8'd5, 8'd5);
        wait_idle_updates(u0 + 9, 100);
        checks++;
        if (upd_q.size() - u0 != 9) $display("FAIL center_count: got %0d want 9", upd_q.size() - u0);
        else passes++;
        for (int k = 0; k < 9; k++) exp_q.push_back({8'(4 + k % 3), 8'(4 + k / 3), 4'(k)});
        check_expected_updates(u0, "center_upd");
        span = (upd_cyc_q.size() >= u0 + 9) ? upd_cyc_q[u0 + 8] - upd_cyc_q[u0] : -1;
        checks++;
        if (span != 8) $display("FAIL center_consecutive: got span %0d want 8", span); else passes++;
        lat = (rd_cyc_q.size() > r0 && upd_cyc_q.size() > u0) ? upd_cyc_q[u0] - rd_cyc_q[r0] : -1;
        checks++;
        if (lat != 2) $display("FAIL first_upd_latency: got %0d want 2", lat); else passes++;
        checks++;
        if (dbg_state !== IDLE) $display("FAIL center_end_state: got %0d want 0", dbg_state); else passes++;
    endtask

    task automatic test_edges();
        int u0;
        u0 = upd_q.size();
        push_event(8'd0, 8'd0);
        push_event(8'd31, 8'd31);
        wait_idle_updates(u0 + 8, 200);
        checks++;
        if (upd_q.size() - u0 != 8) $display("FAIL edge_count: got %0d want 8", upd_q.size() - u0);
        else passes++;
        exp_q.push_back({8'd0, 8'd0, 4'd4});
        exp_q.push_back({8'd1, 8'd0, 4'd5});
        exp_q.push_back({8'd0, 8'd1, 4'd7});
        exp_q.push_back({8'd1, 8'd1, 4'd8});
        exp_q.push_back({8'd30, 8'd30, 4'd0});
        exp_q.push_back({8'd31, 8'd30, 4'd1});
        exp_q.push_back({8'd30, 8'd31, 4'd3});
        exp_q.push_back({8'd31, 8'd31, 4'd4});
        check_expected_updates(u0, "edge_upd");
    endtask

    task automatic check_sweep(input int s0, input int d0, input string name);
        int cnt, err, dgap;
        cnt = sw_q.size() - s0;
        err = 0;
        for (int k = 0; k < cnt; k++)
            if (sw_q[s0 + k] !== {8'(k % W), 8'(k / W)}) err++;
        checks++;
        if (cnt != W * H) $display("FAIL %s_count: got %0d want %0d", name, cnt, W * H); else passes++;
        checks++;
        if (err != 0) $display("FAIL %s_order: got %0d bad want 0", name, err); else passes++;
        dgap = (done_q.size() > d0 && cnt > 0) ? done_q[d0] - sw_cyc_q[sw_cyc_q.size() - 1] : -1;
        checks++;
        if (dgap != 1) $display("FAIL %s_done_timing: got %0d want 1", name, dgap); else passes++;
    endtask

    task automatic test_drain_then_sweep();
        int u0, s0, d0, st0, gap;
        u0 = upd_q.size(); s0 = sw_q.size(); d0 = done_q.size(); st0 = sweep_start_q.size();
        upd_ready = 1'b1; sweep_ready = 1'b1; output_fifo_full = 1'b0;
        push_event(8'd10, 8'd10);
        push_event(8'd20, 8'd3);
        push_event(8'd7, 8'd25);
        pulse_ts();
        wait_done(d0, 3000);
        checks++;
        if (upd_q.size() - u0 != 27) $display("FAIL drain_count: got %0d want 27", upd_q.size() - u0);
        else passes++;
        gap = (sweep_start_q.size() > st0 && upd_cyc_q.size() > 0) ?
              sweep_start_q[st0] - upd_cyc_q[upd_cyc_q.size() - 1] : -1;
        checks++;
        if (gap <= 0) $display("FAIL drain_before_sweep: got gap %0d want >0", gap); else passes++;
        check_sweep(s0, d0, "sweep1");
        checks++;
        if (both_cnt != 0) $display("FAIL valid_exclusive: got %0d want 0", both_cnt); else passes++;
    endtask

    task automatic test_backpressure();
        int s0, d0, u0;
        logic [2*CB+KB:0] held;
        s0 = sw_q.size(); d0 = done_q.size();
        pulse_ts();
        for (int n = 0; n < 6000; n++) begin
            if (done_q.size() > d0) break;
            output_fifo_full = n[1];
            sweep_ready      = (n % 5 != 0);
            tick();
        end
        output_fifo_full = 1'b0; sweep_ready = 1'b1;
        check_sweep(s0, d0, "sweep_bp");
        checks++;
        if (sw_hold_err != 0) $display("FAIL sweep_hold: got %0d want 0", sw_hold_err); else passes++;
        u0 = upd_q.size();
        upd_ready = 1'b0;
        push_event(8'd12, 8'd12);
        for (int n = 0; n < 20 && !upd_valid; n++) tick();
        for (int n = 0; n < 6; n++) begin
            held = {upd_valid, upd_x, upd_y, upd_kidx};
            checks++;
            if (held !== {1'b1, 8'd11, 8'd11, 4'd0})
                $display("FAIL upd_stall[%0d]: got %h want %h", n, held, {1'b1, 8'd11, 8'd11, 4'd0});
            else passes++;
            if (n < 5) tick();
        end
        upd_ready = 1'b1;
        wait_idle_updates(u0 + 9, 100);
        for (int k = 0; k < 9; k++) exp_q.push_back({8'(11 + k % 3), 8'(11 + k / 3), 4'(k)});
        check_expected_updates(u0, "stall_upd");
        checks++;
        if (upd_hold_err != 0) $display("FAIL upd_hold: got %0d want 0", upd_hold_err); else passes++;
    endtask

    task automatic test_overrun();
        int d0, st0;
        d0 = done_q.size(); st0 = sweep_start_q.size();
        checks++;
        if (timestep_overrun !== 1'b0) $display("FAIL overrun_clear: got %b want 0", timestep_overrun);
        else passes++;
        sys_enable = 1'b0;
        pulse_ts();
        tick();
        pulse_ts();
        tick();
        checks++;
        if (timestep_overrun !== 1'b1) $display("FAIL overrun_set: got %b want 1", timestep_overrun);
        else passes++;
        checks++;
        if (sweep_start_q.size() != st0) $display("FAIL disabled_no_sweep: got %0d want 0",
                                                  sweep_start_q.size() - st0);
        else passes++;
        sys_enable = 1'b1;
        wait_done(d0, 3000);
        for (int n = 0; n < 50; n++) tick();
        checks++;
        if (done_q.size() - d0 != 1) $display("FAIL single_sweep: got %0d want 1", done_q.size() - d0);
        else passes++;
        checks++;
        if (timestep_overrun !== 1'b1) $display("FAIL overrun_sticky: got %b want 1", timestep_overrun);
        else passes++;
    endtask

    task automatic test_reset_mid_job();
        logic [41:0] outs;
        int r0, u0, st0, d0;
        upd_ready = 1'b0;
        push_event(8'd8, 8'd8);
        for (int n = 0; n < 20 && !upd_valid; n++) tick();
        sys_reset = 1'b1;
        tick();
        outs = {fifo_rd_en, upd_valid, upd_x, upd_y, upd_kidx, sweep_valid, sweep_x, sweep_y,
                timestep_done, timestep_overrun, system_active};
        checks++;
        if (outs !== 42'd0) $display("FAIL reset_window_outputs: got %h want 0", outs); else passes++;
        checks++;
        if (dbg_state !== IDLE) $display("FAIL reset_window_state: got %0d want 0", dbg_state); else passes++;
        sys_reset = 1'b0;
        upd_ready = 1'b1;
        r0 = rd_cyc_q.size(); u0 = upd_q.size();
        for (int n = 0; n < 10; n++) tick();
        checks++;
        if (rd_cyc_q.size() != r0 || upd_q.size() != u0)
            $display("FAIL reset_window_quiet: got rd %0d upd %0d want 0 0",
                     rd_cyc_q.size() - r0, upd_q.size() - u0);
        else passes++;
        sweep_ready = 1'b1; output_fifo_full = 1'b0;
        pulse_ts();
        for (int n = 0; n < 20 && !sweep_valid; n++) tick();
        for (int n = 0; n < 40; n++) tick();
        sys_reset = 1'b1;
        tick();
        outs = {fifo_rd_en, upd_valid, upd_x, upd_y, upd_kidx, sweep_valid, sweep_x, sweep_y,
                timestep_done, timestep_overrun, system_active};
        checks++;
        if (outs !== 42'd0) $display("FAIL reset_sweep_outputs: got %h want 0", outs); else passes++;
        sys_reset = 1'b0;
        st0 = sweep_start_q.size(); d0 = done_q.size(); r0 = rd_cyc_q.size();
        for (int n = 0; n < 40; n++) tick();
        checks++;
        if (sweep_start_q.size() != st0 || done_q.size() != d0 || rd_cyc_q.size() != r0)
            $display("FAIL reset_sweep_pending: got sweeps %0d done %0d rd %0d want 0 0 0",
                     sweep_start_q.size() - st0, done_q.size() - d0, rd_cyc_q.size() - r0);
        else passes++;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        sys_reset = 1'b1; sys_enable = 1'b0; timestep = 1'b0; upd_ready = 1'b0;
        sweep_ready = 1'b0; output_fifo_full = 1'b0;
        tick(); tick(); tick();
        test_reset();
        sys_reset = 1'b0;
        tick();
        test_single_window();
        test_edges();
        test_drain_then_sweep();
        test_backpressure();
        test_overrun();
        test_reset_mid_job();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
